// File: rtl/dlfloat16_pkg.sv
// Shared constants and types for the dlfloat16 add/sub arbiter.
package dlfloat16_pkg;

    localparam logic [3:0] ENA_ADDSUB = 4'b0001;
    localparam logic [3:0] ENA_OFF    = 4'b0000;

    // Bit positions within the 5-bit exception vector.
    localparam int unsigned INVALID   = 4;
    localparam int unsigned INEXACT   = 3;
    localparam int unsigned OVERFLOW  = 2;
    localparam int unsigned UNDERFLOW = 1;
    localparam int unsigned DIV_ZERO  = 0;

    localparam int unsigned EXC_W = 5;

    localparam logic [15:0] ONE = 16'h3E00;
    localparam logic [15:0] TWO = 16'h4000;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

endpackage

// File: rtl/dlfloat16_addsub_arbiter_if.sv
// Request/response, FPU-side and sticky-status signals of the add/sub arbiter.
interface dlfloat16_addsub_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*16-1:0] req_a;
    logic [NUM_REQ*16-1:0] req_b;
    logic [NUM_REQ-1:0]    req_op;

    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [15:0]           rsp_data;
    logic [4:0]            rsp_exc;

    logic [15:0]           fpu_a;
    logic [15:0]           fpu_b;
    logic                  fpu_op;
    logic [3:0]            fpu_ena;
    logic [31:0]           fpu_c;
    logic [4:0]            fpu_exc;

    logic [4:0]            exc_sticky;
    logic                  exc_clr;

    // Requesters plus the add/sub unit, seen from outside the arbiter.
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, fpu_c, fpu_exc, exc_clr,
        input  req_ready, rsp_valid, rsp_data, rsp_exc, fpu_a, fpu_b, fpu_op, fpu_ena,
        input  exc_sticky
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, fpu_c, fpu_exc, exc_clr,
        output req_ready, rsp_valid, rsp_data, rsp_exc, fpu_a, fpu_b, fpu_op, fpu_ena,
        output exc_sticky
    );

endinterface

// File: rtl/dlfloat16_rr_pick.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping to 0.
module dlfloat16_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    always_comb begin
        int unsigned cand;
        cand  = 0;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = 32'(ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                idx       = IDX_W'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dlfloat16_addsub_arbiter.sv
// Shares one dlfloat16 add/sub unit among NUM_REQ requesters, one op in flight.
// Optional sticky exception status is built when DLFP_ARB_STICKY_EXC_EN is defined.
module dlfloat16_addsub_arbiter
    import dlfloat16_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input logic                         clk,
    input logic                         rst_n,
    dlfloat16_addsub_arbiter_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_e state_q, state_d;

    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   rr_ptr_next;
    logic [IDX_W-1:0]   gnt_idx_q;
    logic [15:0]        a_q;
    logic [15:0]        b_q;
    logic               op_q;
    logic [15:0]        rsp_data_q;
    logic [EXC_W-1:0]   rsp_exc_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               accept;

    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [3:0]         fpu_ena;

    dlfloat16_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign accept      = (state_q == StIdle) && pick_found;
    assign rr_ptr_next = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        fpu_ena   = ENA_OFF;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    req_ready = pick_gnt;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                fpu_ena = ENA_ADDSUB;
                state_d = StWait;
            end
            StWait: begin
                state_d = StResp;
            end
            StResp: begin
                rsp_valid[gnt_idx_q] = 1'b1;
                // Only the granted requester's ready can retire the response.
                if (bus.rsp_ready[gnt_idx_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            gnt_idx_q  <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_exc_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q       <= bus.req_a[pick_idx*16 +: 16];
                b_q       <= bus.req_b[pick_idx*16 +: 16];
                op_q      <= bus.req_op[pick_idx];
                gnt_idx_q <= pick_idx;
                rr_ptr_q  <= rr_ptr_next;
            end
            if (state_q == StWait) begin
                rsp_data_q <= bus.fpu_c[15:0];
                rsp_exc_q  <= bus.fpu_exc;
            end
        end
    end

    // Operand latches drive the unit directly, so they hold between ops.
    assign bus.fpu_a     = a_q;
    assign bus.fpu_b     = b_q;
    assign bus.fpu_op    = op_q;
    assign bus.fpu_ena   = fpu_ena;
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_exc   = rsp_exc_q;

    logic unused_fpu_c_hi;
    assign unused_fpu_c_hi = ^bus.fpu_c[31:16];

`ifdef DLFP_ARB_STICKY_EXC_EN
    logic [EXC_W-1:0] sticky_q, sticky_d;

    // Clear applies before the new flags are merged, so a same-cycle capture survives.
    always_comb begin
        sticky_d = bus.exc_clr ? '0 : sticky_q;
        if (state_q == StWait) begin
            sticky_d = sticky_d | bus.fpu_exc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign bus.exc_sticky = sticky_q;
`else
    logic unused_exc_clr;
    assign unused_exc_clr = bus.exc_clr;
    assign bus.exc_sticky = '0;
`endif

endmodule
